// File: rtl/cxu_mac.sv
// CX-unit multiply/accumulate engine: an iterative shift-add multiplier feeding
// N_STATE accumulator contexts, with a request/reply handshake toward the CX switch.
module cxu_mac #(
    parameter int unsigned BITS_PER_CYCLE = 1,
    parameter int unsigned N_STATE        = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cxu_req,
    input  logic [2:0]  cxu_func,
    input  logic [1:0]  cxu_state_id,
    input  logic [31:0] cxu_data0,
    input  logic [31:0] cxu_data1,
    output logic        cxu_reply,
    output logic [31:0] cxu_response,
    output logic [3:0]  cxu_status,
    output logic        busy
);

    localparam int unsigned STEPS = 32 / BITS_PER_CYCLE;

    localparam logic [2:0] F_MAC   = 3'd0;
    localparam logic [2:0] F_MUL   = 3'd1;
    localparam logic [2:0] F_READ  = 3'd2;
    localparam logic [2:0] F_WRITE = 3'd3;
    localparam logic [2:0] F_CLEAR = 3'd4;

    localparam logic [3:0] ST_OK      = 4'h0;
    localparam logic [3:0] ST_ILLEGAL = 4'h1;
    localparam logic [3:0] ST_CARRY   = 4'h2;

    typedef enum logic [2:0] {
        IDLE,
        EXEC,
        MULT,
        REPLY,
        DRAIN
    } state_t;

    state_t      r_state;
    state_t      w_next;

    logic [2:0]  r_func;
    logic [1:0]  r_id;
    logic [31:0] r_a;
    logic [31:0] r_mcand;
    logic [31:0] r_mplier;
    logic [31:0] r_prod;
    logic [5:0]  r_cnt;
    logic [31:0] r_acc [N_STATE];

    logic        r_reply;
    logic [31:0] r_resp;
    logic [3:0]  r_status;

    logic [31:0] w_step_add;
    logic [31:0] w_prod_next;
    logic [31:0] w_acc_sel;
    logic [32:0] w_sum;
    logic        w_id_ok;
    logic        w_func_ok;
    logic        w_commit;
    logic        w_acc_we;
    logic [31:0] w_acc_wdata;
    logic [31:0] w_resp;
    logic [3:0]  w_status;

    // ---------------- next-state ----------------
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (cxu_req) begin
                    w_next = (cxu_func == F_MAC || cxu_func == F_MUL) ? MULT : EXEC;
                end
            end
            EXEC: begin
                w_next = cxu_req ? REPLY : IDLE;
            end
            MULT: begin
                if (!cxu_req) begin
                    w_next = IDLE;
                end else if (r_cnt == 6'(STEPS - 1)) begin
                    w_next = REPLY;
                end
            end
            REPLY: begin
                w_next = DRAIN;
            end
            DRAIN: begin
                if (!cxu_req) begin
                    w_next = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    // Results and accumulator writes only take effect on the transition into REPLY.
    assign w_commit = (r_state == EXEC || r_state == MULT) && (w_next == REPLY);

    // ---------------- datapath ----------------
    always_comb begin
        w_step_add = '0;
        for (int unsigned i = 0; i < BITS_PER_CYCLE; i++) begin
            if (r_mplier[i]) begin
                w_step_add = w_step_add + (r_mcand << i);
            end
        end
    end

    assign w_prod_next = r_prod + w_step_add;

    always_comb begin
        w_acc_sel = '0;
        for (int unsigned i = 0; i < N_STATE; i++) begin
            if ({30'b0, r_id} == i) begin
                w_acc_sel = r_acc[i];
            end
        end
    end

    assign w_sum     = {1'b0, w_acc_sel} + {1'b0, w_prod_next};
    assign w_id_ok   = ({30'b0, r_id} < N_STATE);
    assign w_func_ok = (r_func <= F_CLEAR);

    always_comb begin
        w_acc_we    = 1'b0;
        w_acc_wdata = '0;
        w_resp      = '0;
        w_status    = ST_OK;
        if (!w_func_ok || !w_id_ok) begin
            w_status = ST_ILLEGAL;
        end else begin
            case (r_func)
                F_MAC: begin
                    w_acc_we    = 1'b1;
                    w_acc_wdata = w_sum[31:0];
                    w_resp      = w_sum[31:0];
                    w_status    = w_sum[32] ? ST_CARRY : ST_OK;
                end
                F_MUL:   w_resp = w_prod_next;
                F_READ:  w_resp = w_acc_sel;
                F_WRITE: begin
                    w_acc_we    = 1'b1;
                    w_acc_wdata = r_a;
                    w_resp      = w_acc_sel;
                end
                F_CLEAR: w_acc_we = 1'b1;
                default: w_status = ST_ILLEGAL;
            endcase
        end
    end

    // ---------------- sequential ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_func   <= '0;
            r_id     <= '0;
            r_a      <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_prod   <= '0;
            r_cnt    <= '0;
            r_reply  <= 1'b0;
            r_resp   <= '0;
            r_status <= '0;
            for (int unsigned i = 0; i < N_STATE; i++) begin
                r_acc[i] <= '0;
            end
        end else begin
            r_state  <= w_next;
            r_reply  <= w_commit;
            r_resp   <= w_commit ? w_resp : '0;
            r_status <= w_commit ? w_status : '0;

            if (r_state == IDLE && cxu_req) begin
                r_func   <= cxu_func;
                r_id     <= cxu_state_id;
                r_a      <= cxu_data0;
                r_mcand  <= cxu_data0;
                r_mplier <= cxu_data1;
                r_prod   <= '0;
                r_cnt    <= '0;
            end else if (r_state == MULT && w_next == MULT) begin
                r_prod   <= w_prod_next;
                r_mcand  <= r_mcand << BITS_PER_CYCLE;
                r_mplier <= r_mplier >> BITS_PER_CYCLE;
                r_cnt    <= r_cnt + 6'd1;
            end

            if (w_commit && w_acc_we) begin
                for (int unsigned i = 0; i < N_STATE; i++) begin
                    if ({30'b0, r_id} == i) begin
                        r_acc[i] <= w_acc_wdata;
                    end
                end
            end
        end
    end

    assign cxu_reply    = r_reply;
    assign cxu_response = r_resp;
    assign cxu_status   = r_status;
    assign busy         = (r_state != IDLE);

endmodule

// File: tb/tb_cxu_mac.sv
// Directed bench for cxu_mac: one default instance (1 bit/cycle) and one at
// 4 bits/cycle, selected by sel; expectations are hand-computed constants.
module tb_cxu_mac;

    logic        clk = 1'b0;
    logic        rst;
    logic        req;
    logic        sel;
    logic [2:0]  func;
    logic [1:0]  sid;
    logic [31:0] d0, d1;

    logic        reply0, reply1, busy0, busy1;
    logic [31:0] resp0, resp1;
    logic [3:0]  stat0, stat1;

    logic        o_reply, o_busy;
    logic [31:0] o_resp;
    logic [3:0]  o_stat;

    int n_total = 0;
    int n_pass  = 0;

    always #5 clk = ~clk;

    cxu_mac u_dut1 (
        .clk(clk), .rst(rst), .cxu_req(req & ~sel), .cxu_func(func),
        .cxu_state_id(sid), .cxu_data0(d0), .cxu_data1(d1),
        .cxu_reply(reply0), .cxu_response(resp0), .cxu_status(stat0), .busy(busy0)
    );

    cxu_mac #(.BITS_PER_CYCLE(4), .N_STATE(4)) u_dut4 (
        .clk(clk), .rst(rst), .cxu_req(req & sel), .cxu_func(func),
        .cxu_state_id(sid), .cxu_data0(d0), .cxu_data1(d1),
        .cxu_reply(reply1), .cxu_response(resp1), .cxu_status(stat1), .busy(busy1)
    );

    assign o_reply = sel ? reply1 : reply0;
    assign o_busy  = sel ? busy1  : busy0;
    assign o_resp  = sel ? resp1  : resp0;
    assign o_stat  = sel ? stat1  : stat0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    // Starts at a negedge, ends at a negedge with the DUT back in IDLE.
    task automatic do_op(input string tag, input logic [2:0] f, input logic [1:0] id,
                         input logic [31:0] a, input logic [31:0] b, input int hold,
                         output logic [31:0] r, output logic [3:0] st,
                         output int lat, output int pulses);
        bit seen = 1'b0;
        r = '0; st = '0; lat = 0; pulses = 0;
        func = f; sid = id; d0 = a; d1 = b; req = 1'b1;
        @(posedge clk);
        for (int k = 1; k <= 100 && !seen; k++) begin
            @(negedge clk);
            if (o_reply) begin
                seen = 1'b1; lat = k; r = o_resp; st = o_stat; pulses = 1;
            end else begin
                @(posedge clk);
            end
        end
        if (!seen) check({tag, ".timeout"}, 32'd0, 32'd1);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); @(negedge clk);
            if (o_reply) pulses++;
        end
        req = 1'b0;
        repeat (2) begin
            @(posedge clk); @(negedge clk);
            if (o_reply) pulses++;
        end
    endtask

    task automatic op_chk(input string tag, input logic [2:0] f, input logic [1:0] id,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] er, input logic [3:0] est, input int elat);
        logic [31:0] r;
        logic [3:0]  st;
        int lat, pulses;
        do_op(tag, f, id, a, b, 0, r, st, lat, pulses);
        check({tag, ".resp"}, r, er);
        check({tag, ".status"}, {28'd0, st}, {28'd0, est});
        check({tag, ".latency"}, lat, elat);
        check({tag, ".pulses"}, pulses, 1);
    endtask

    initial begin
        logic [31:0] r;
        logic [3:0]  st;
        int lat, pulses, replies;

        rst = 1'b1; req = 1'b0; sel = 1'b0;
        func = '0; sid = '0; d0 = '0; d1 = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst.reply", {31'd0, o_reply}, 32'd0);
        check("rst.resp", o_resp, 32'd0);
        check("rst.status", {28'd0, o_stat}, 32'd0);
        check("rst.busy", {31'd0, o_busy}, 32'd0);
        rst = 1'b0;

        // Write then MAC into context 1: 0x10 + 3*5
        op_chk("wr1", 3'd3, 2'd1, 32'h10, 32'h0, 32'h0, 4'h0, 2);
        op_chk("mac1", 3'd0, 2'd1, 32'd3, 32'd5, 32'h1F, 4'h0, 33);
        op_chk("rd1", 3'd2, 2'd1, 32'h0, 32'h0, 32'h1F, 4'h0, 2);

        // Wrapping MAC: 2 + 0xFFFFFFFE
        op_chk("wr0", 3'd3, 2'd0, 32'd2, 32'h0, 32'h0, 4'h0, 2);
        op_chk("macwrap", 3'd0, 2'd0, 32'hFFFFFFFF, 32'd2, 32'h0, 4'h2, 33);
        op_chk("rd0wrap", 3'd2, 2'd0, 32'h0, 32'h0, 32'h0, 4'h0, 2);
        op_chk("wr2", 3'd3, 2'd2, 32'hDEADBEEF, 32'h0, 32'h0, 4'h0, 2);
        op_chk("wr3", 3'd3, 2'd3, 32'h12345678, 32'h0, 32'h0, 4'h0, 2);

        // Illegal funcs leave every context untouched
        op_chk("ill6", 3'd6, 2'd2, 32'hAAAA5555, 32'h1234, 32'h0, 4'h1, 2);
        op_chk("ill5", 3'd5, 2'd1, 32'h1, 32'h1, 32'h0, 4'h1, 2);
        op_chk("ill7", 3'd7, 2'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 4'h1, 2);
        op_chk("rdall0", 3'd2, 2'd0, 32'h0, 32'h0, 32'h0, 4'h0, 2);
        op_chk("rdall1", 3'd2, 2'd1, 32'h0, 32'h0, 32'h1F, 4'h0, 2);
        op_chk("rdall2", 3'd2, 2'd2, 32'h0, 32'h0, 32'hDEADBEEF, 4'h0, 2);
        op_chk("rdall3", 3'd2, 2'd3, 32'h0, 32'h0, 32'h12345678, 4'h0, 2);

        // MUL returns the product without touching the context
        op_chk("mul", 3'd1, 2'd2, 32'd1234, 32'd5678, 32'd7006652, 4'h0, 33);
        op_chk("rdmul2", 3'd2, 2'd2, 32'h0, 32'h0, 32'hDEADBEEF, 4'h0, 2);
        op_chk("clr3", 3'd4, 2'd3, 32'h99, 32'h0, 32'h0, 4'h0, 2);
        op_chk("rdclr3", 3'd2, 2'd3, 32'h0, 32'h0, 32'h0, 4'h0, 2);

        // Request held high after reply: single pulse, stays busy in drain
        do_op("hold", 3'd3, 2'd0, 32'h55, 32'h0, 3, r, st, lat, pulses);
        check("hold.resp", r, 32'h0);
        check("hold.pulses", pulses, 1);
        check("hold.idle", {31'd0, o_busy}, 32'd0);
        req = 1'b1; func = 3'd2; sid = 2'd0;
        @(posedge clk); @(negedge clk);
        check("hold.busy", {31'd0, o_busy}, 32'd1);
        req = 1'b0;
        repeat (2) begin @(posedge clk); @(negedge clk); end

        // Abort mid-multiply
        replies = 0;
        func = 3'd0; sid = 2'd0; d0 = 32'd1; d1 = 32'd1; req = 1'b1;
        @(posedge clk);
        repeat (5) begin @(negedge clk); if (o_reply) replies++; end
        req = 1'b0;
        @(posedge clk); @(negedge clk);
        check("abort.busy", {31'd0, o_busy}, 32'd0);
        repeat (2) begin @(posedge clk); @(negedge clk); if (o_reply) replies++; end
        check("abort.replies", replies, 0);
        op_chk("rdabort", 3'd2, 2'd0, 32'h0, 32'h0, 32'h55, 4'h0, 2);

        // Reset ten cycles into a MAC; first request right after reset
        replies = 0;
        func = 3'd0; sid = 2'd0; d0 = 32'd7; d1 = 32'd9; req = 1'b1;
        @(posedge clk);
        repeat (10) begin @(negedge clk); if (o_reply) replies++; end
        rst = 1'b1; req = 1'b0;
        @(posedge clk); @(negedge clk);
        if (o_reply) replies++;
        check("rstmid.replies", replies, 0);
        check("rstmid.busy", {31'd0, o_busy}, 32'd0);
        rst = 1'b0;
        op_chk("rdrst0", 3'd2, 2'd0, 32'h0, 32'h0, 32'h0, 4'h0, 2);
        op_chk("rdrst1", 3'd2, 2'd1, 32'h0, 32'h0, 32'h0, 4'h0, 2);

        // 4 bits/cycle instance
        sel = 1'b1;
        op_chk("mul4big", 3'd1, 2'd0, 32'h10000, 32'h10000, 32'h0, 4'h0, 9);
        op_chk("mul4", 3'd1, 2'd1, 32'd3, 32'd7, 32'd21, 4'h0, 9);
        op_chk("mac4", 3'd0, 2'd0, 32'd5, 32'd6, 32'd30, 4'h0, 9);
        op_chk("rd4_0", 3'd2, 2'd0, 32'h0, 32'h0, 32'd30, 4'h0, 2);
        op_chk("rd4_1", 3'd2, 2'd1, 32'h0, 32'h0, 32'h0, 4'h0, 2);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
